// File: rtl/register_file_ckpt_if.sv
// Bundle between the register file and its neighbours: instruction unit
// (reads, rename), ROB (commit, forwarding) and branch logic (checkpoints).
// master drives requests; slave is the register file.
interface register_file_ckpt_if #(
    parameter int XLEN       = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int READ_PORTS = 2,
    parameter int CKPT_DEPTH = 4
);
    localparam int CW = $clog2(CKPT_DEPTH);

    logic                            clearIn;
    logic                            readyIn;
    logic [5*READ_PORTS-1:0]         rdAddr;
    logic [READ_PORTS-1:0]           rdDirty;
    logic [ROB_WIDTH*READ_PORTS-1:0] rdDep;
    logic [XLEN*READ_PORTS-1:0]      rdValue;
    logic [ROB_WIDTH*READ_PORTS-1:0] robQueryDep;
    logic [READ_PORTS-1:0]           robQueryReady;
    logic [XLEN*READ_PORTS-1:0]      robQueryValue;
    logic                            renameValid;
    logic [4:0]                      renameDest;
    logic [ROB_WIDTH-1:0]            renameRobId;
    logic                            commitValid;
    logic [4:0]                      commitDest;
    logic [XLEN-1:0]                 commitValue;
    logic [ROB_WIDTH-1:0]            commitRobId;
    logic                            ckptSaveValid;
    logic                            ckptSaveReady;
    logic [CW-1:0]                   ckptSaveId;
    logic                            ckptRestoreValid;
    logic [CW-1:0]                   ckptRestoreId;
    logic                            ckptReleaseValid;
    logic [CW:0]                     ckptCount;

    modport master (
        output clearIn, readyIn, rdAddr,
        output robQueryReady, robQueryValue,
        output renameValid, renameDest, renameRobId,
        output commitValid, commitDest, commitValue, commitRobId,
        output ckptSaveValid, ckptRestoreValid, ckptRestoreId,
        output ckptReleaseValid,
        input  rdDirty, rdDep, rdValue, robQueryDep,
        input  ckptSaveReady, ckptSaveId, ckptCount
    );

    modport slave (
        input  clearIn, readyIn, rdAddr,
        input  robQueryReady, robQueryValue,
        input  renameValid, renameDest, renameRobId,
        input  commitValid, commitDest, commitValue, commitRobId,
        input  ckptSaveValid, ckptRestoreValid, ckptRestoreId,
        input  ckptReleaseValid,
        output rdDirty, rdDep, rdValue, robQueryDep,
        output ckptSaveReady, ckptSaveId, ckptCount
    );
endinterface

// File: rtl/register_file_ckpt.sv
// Architectural register file + rename table with a FIFO of rename-table
// checkpoints for one-cycle mispredict recovery.
// Ports: clockIn, resetIn (async, active-low), bus (slave side of the bundle).
module register_file_ckpt #(
    parameter int XLEN       = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int READ_PORTS = 2,
    parameter int CKPT_DEPTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    register_file_ckpt_if.slave  bus
);
    localparam int CW = $clog2(CKPT_DEPTH);
    localparam int RW = ROB_WIDTH;

    typedef logic [RW-1:0] tag_t;

    logic [XLEN-1:0] regs [32];
    logic [31:0]     busy;
    tag_t            tags [32];
    logic [31:0]     snapBusy [CKPT_DEPTH];
    tag_t            snapTag [CKPT_DEPTH][32];
    logic [4:0]      rdAddrQ [READ_PORTS];
    logic [CW-1:0]   head;
    logic [CW-1:0]   tail;
    logic [CW:0]     count;

    logic        saveReady;
    logic        cmt;
    logic        go;
    logic        doClr;
    logic        doRst;
    logic        doSave;
    logic        doRen;
    logic        doRel;
    logic        inWin;
    logic [31:0] busyC;
    logic [31:0] rstBusy;

    // Count never exceeds CKPT_DEPTH, so its MSB alone flags "full".
    assign saveReady = ~count[CW];

    assign cmt    = bus.commitValid & (bus.commitDest != 5'd0);
    assign go     = bus.readyIn & ~bus.clearIn;
    assign doClr  = bus.readyIn & bus.clearIn;
    assign doRst  = go & bus.ckptRestoreValid;
    assign doSave = go & ~bus.ckptRestoreValid
                  & bus.ckptSaveValid & saveReady;
    assign doRen  = go & ~bus.ckptRestoreValid
                  & bus.renameValid & (bus.renameDest != 5'd0);
    assign doRel  = go & ~bus.ckptRestoreValid
                  & bus.ckptReleaseValid & (count != '0);

    assign inWin = {1'b0, bus.ckptRestoreId - head} < count;

    // Live table and the restore source, both with this cycle's commit
    // already retired. busyC is also what a save captures (pre-rename).
    always_comb begin
        busyC   = busy;
        rstBusy = snapBusy[bus.ckptRestoreId];
        if (cmt && tags[bus.commitDest] == bus.commitRobId)
            busyC[bus.commitDest] = 1'b0;
        if (cmt && snapTag[bus.ckptRestoreId][bus.commitDest] == bus.commitRobId)
            rstBusy[bus.commitDest] = 1'b0;
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            busy <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
            for (int p = 0; p < READ_PORTS; p++)
                rdAddrQ[p] <= '0;
        end else begin
            if (cmt)
                regs[bus.commitDest] <= bus.commitValue;
            if (bus.readyIn)
                for (int p = 0; p < READ_PORTS; p++)
                    rdAddrQ[p] <= bus.rdAddr[p*5 +: 5];
            if (doClr) begin
                busy <= '0;
            end else if (doRst) begin
                busy <= rstBusy;
                for (int i = 0; i < 32; i++)
                    tags[i] <= snapTag[bus.ckptRestoreId][i];
            end else begin
                busy <= busyC;
                if (doRen) begin
                    busy[bus.renameDest] <= 1'b1;
                    tags[bus.renameDest] <= bus.renameRobId;
                end
            end
        end
    end

    // Commits scrub every snapshot so a later restore cannot bring back
    // a producer that has already retired.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            for (int k = 0; k < CKPT_DEPTH; k++) begin
                snapBusy[k] <= '0;
                for (int i = 0; i < 32; i++)
                    snapTag[k][i] <= '0;
            end
        end else begin
            for (int k = 0; k < CKPT_DEPTH; k++)
                if (cmt && snapTag[k][bus.commitDest] == bus.commitRobId)
                    snapBusy[k][bus.commitDest] <= 1'b0;
            if (doSave) begin
                snapBusy[tail] <= busyC;
                for (int i = 0; i < 32; i++)
                    snapTag[tail][i] <= tags[i];
            end
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (doClr) begin
            head  <= tail;
            count <= '0;
        end else if (doRst) begin
            // Restored slot and everything younger are discarded.
            tail  <= bus.ckptRestoreId;
            count <= {1'b0, bus.ckptRestoreId - head};
        end else begin
            if (doSave)
                tail <= tail + 1'b1;
            if (doRel)
                head <= head + 1'b1;
            count <= count + {{CW{1'b0}}, doSave} - {{CW{1'b0}}, doRel};
        end
    end

    always_comb begin
        bus.rdDirty = '0;
        bus.rdDep   = '0;
        bus.rdValue = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            bus.rdDirty[p] = busy[rdAddrQ[p]] & ~bus.robQueryReady[p];
            bus.rdDep[p*RW +: RW] = tags[rdAddrQ[p]];
            bus.rdValue[p*XLEN +: XLEN] = busy[rdAddrQ[p]]
                ? bus.robQueryValue[p*XLEN +: XLEN]
                : regs[rdAddrQ[p]];
        end
    end

    assign bus.robQueryDep   = bus.rdDep;
    assign bus.ckptSaveReady = saveReady;
    assign bus.ckptSaveId    = tail;
    assign bus.ckptCount     = count;

    ap_restore_window: assert property (
        @(posedge clockIn) disable iff (!resetIn) doRst |-> inWin);

    ap_restore_release: assert property (
        @(posedge clockIn) disable iff (!resetIn)
        !(doRst && bus.ckptReleaseValid));

endmodule
